// File: rtl/ps2_kbd_receiver.sv
// ps2_kbd_receiver
// Receives PS/2 keyboard frames (start, 8 data bits LSB first, odd parity, stop)
// and queues the scan codes in a small FIFO for the host.
//
// Ports
//   clk         system clock; all state changes on its rising edge
//   clrn        asynchronous active-low reset
//   ps2_clk     PS/2 clock line (asynchronous to clk)
//   ps2_data    PS/2 data line (asynchronous to clk)
//   nextdata_n  active-low pop request for the FIFO head
//   data        FIFO head scan code (don't-care while ready = 0)
//   ready       FIFO holds at least one code
//   overflow    sticky: a good frame was dropped because the FIFO was full
//   frame_err   sticky: a frame failed its start, stop or parity check
module ps2_kbd_receiver #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  // ---------------------------------------------------------------------------
  // Synchronizers
  // ---------------------------------------------------------------------------
  logic [2:0] r_clk_sync;
  logic [1:0] r_data_sync;

  // Both chains reset to the idle-high level so reset release on an idle bus
  // cannot look like a falling edge.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_clk_sync  <= 3'b111;
      r_data_sync <= 2'b11;
    end else begin
      r_clk_sync  <= {r_clk_sync[1:0], ps2_clk};
      r_data_sync <= {r_data_sync[0], ps2_data};
    end
  end

  logic w_fall;
  assign w_fall = r_clk_sync[2] & ~r_clk_sync[1];

  // ---------------------------------------------------------------------------
  // Frame assembly
  // ---------------------------------------------------------------------------
  // r_frame keeps the previous ten samples with the oldest in bit 0; w_frame
  // appends the current sample, so at count 10 it is the whole 11-bit frame.
  logic [9:0]    r_frame;
  logic [3:0]    r_bit_cnt;
  logic [TW-1:0] r_tmo_cnt;
  logic [10:0]   w_frame;
  logic          w_last;
  logic          w_frame_ok;
  logic          w_push;
  logic          w_tmo;

  assign w_frame    = {r_data_sync[1], r_frame};
  assign w_last     = w_fall && (r_bit_cnt == 4'd10);
  // Start low, stop high, odd parity across data plus parity bit.
  assign w_frame_ok = ~w_frame[0] & w_frame[10] & (^w_frame[9:1]);
  assign w_push     = w_last & w_frame_ok;
  // Fires on the TIMEOUT_CYCLES-th consecutive edge-free cycle mid-frame.
  assign w_tmo      = (r_bit_cnt != 4'd0) && !w_fall &&
                      (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_frame   <= '0;
      r_bit_cnt <= 4'd0;
      r_tmo_cnt <= '0;
      frame_err <= 1'b0;
    end else begin
      if (w_fall) begin
        r_frame   <= w_frame[10:1];
        r_tmo_cnt <= '0;
        if (r_bit_cnt == 4'd10) begin
          r_bit_cnt <= 4'd0;
        end else begin
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
      end else if (r_bit_cnt != 4'd0) begin
        if (w_tmo) begin
          // Silent abort: a stalled keyboard is not a framing error.
          r_bit_cnt <= 4'd0;
          r_tmo_cnt <= '0;
        end else begin
          r_tmo_cnt <= r_tmo_cnt + TW'(1);
        end
      end else begin
        r_tmo_cnt <= '0;
      end

      if (w_last && !w_frame_ok) begin
        frame_err <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scan-code FIFO
  // ---------------------------------------------------------------------------
  // Pointers carry one extra wrap bit: equal means empty, equal apart from the
  // wrap bit means full.
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_wr;
  logic          w_drop;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = ~nextdata_n & ~w_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO succeeds.
  assign w_wr    = w_push & (~w_full | w_pop);
  assign w_drop  = w_push & w_full & ~w_pop;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      if (w_drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset; entries are only visible once written.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr[AW-1:0]] <= w_frame[8:1];
    end
  end

  assign ready = ~w_empty;
  assign data  = r_mem[r_rptr[AW-1:0]];

endmodule

// File: tb/tb_ps2_kbd_receiver.sv
// Bench for ps2_kbd_receiver: a keyboard driver plus a queue-based model of
// what the receiver must hold; one compare process checks the outputs against
// the model on every cycle the model is settled.
module tb_ps2_kbd_receiver;

  localparam int unsigned DEPTH = 8;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  always #5 clk = ~clk;

  ps2_kbd_receiver #(
    .FIFO_DEPTH    (DEPTH),
    .TIMEOUT_CYCLES(1000)
  ) dut (
    .clk       (clk),
    .clrn      (clrn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .nextdata_n(nextdata_n),
    .data      (data),
    .ready     (ready),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: the codes the FIFO must hold, plus the two sticky flags.
  byte unsigned mdl_q[$];
  bit           mdl_ovf = 1'b0;
  bit           mdl_err = 1'b0;
  bit           mdl_valid = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    return {1'b1, ~(^b), b, 1'b0};
  endfunction

  always @(negedge clk) begin
    if (mdl_valid) begin
      check("cmp_ready", int'(ready), (mdl_q.size() != 0) ? 1 : 0);
      check("cmp_overflow", int'(overflow), int'(mdl_ovf));
      check("cmp_frame_err", int'(frame_err), int'(mdl_err));
      if (mdl_q.size() != 0) check("cmp_data", int'(data), int'(mdl_q[0]));
    end
  end

  task automatic do_reset();
    mdl_valid  = 1'b0;
    clrn       = 1'b0;
    ps2_clk    = 1'b1;
    ps2_data   = 1'b1;
    nextdata_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", int'(ready), 0);
    check("rst_flags", int'({overflow, frame_err}), 0);
    mdl_q.delete();
    mdl_ovf = 1'b0;
    mdl_err = 1'b0;
    clrn    = 1'b1;
    @(negedge clk);
    mdl_valid = 1'b1;
  endtask

  // Sends the first nbits of frame f at a 60 ns bit period. Optionally holds
  // nextdata_n low across the cycle in which the stop bit is pushed, and/or
  // measures clk cycles from the stop-bit ps2_clk fall to ready.
  task automatic send_frame(input logic [10:0] f, input int nbits,
                            input bit pop_at_stop, input bit chk_lat);
    int lat;
    bit popped;
    bit ok;
    lat = 0;
    mdl_valid = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (3) @(negedge clk);
      ps2_clk = 1'b0;
      for (int k = 1; k <= 3; k++) begin
        @(negedge clk);
        if (i == 10) begin
          if (chk_lat && lat == 0 && ready) lat = k;
          if (pop_at_stop && k == 2) nextdata_n = 1'b0;
          if (pop_at_stop && k == 3) nextdata_n = 1'b1;
        end
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    if (chk_lat) check("stop_edge_to_ready_clks", lat, 3);
    if (nbits == 11) begin
      popped = pop_at_stop && (mdl_q.size() != 0);
      if (popped) void'(mdl_q.pop_front());
      ok = (f[0] == 1'b0) && (f[10] == 1'b1) && (^f[9:1] == 1'b1);
      if (!ok) mdl_err = 1'b1;
      else if (mdl_q.size() < DEPTH) mdl_q.push_back(f[8:1]);
      else mdl_ovf = 1'b1;
    end
    repeat (3) @(negedge clk);
    mdl_valid = 1'b1;
  endtask

  task automatic pop_n(input int n);
    mdl_valid  = 1'b0;
    nextdata_n = 1'b0;
    repeat (n) @(negedge clk);
    nextdata_n = 1'b1;
    for (int i = 0; i < n; i++) if (mdl_q.size() != 0) void'(mdl_q.pop_front());
    mdl_valid = 1'b1;
  endtask

  initial begin
    logic [10:0] f;
    logic [7:0]  b;
    int          r;
    int          sel;

    // Reset state, then pin the frame builder to hand-computed frames.
    repeat (3) @(negedge clk);
    check("reset_ready", int'(ready), 0);
    check("reset_overflow", int'(overflow), 0);
    check("reset_frame_err", int'(frame_err), 0);
    clrn = 1'b1;
    @(negedge clk);
    mdl_valid = 1'b1;
    check("frame_of_1C", int'(frame_of(8'h1C)), 'h438);
    check("frame_of_5A", int'(frame_of(8'h5A)), 'h6B4);

    // Single frame.
    send_frame(frame_of(8'h1C), 11, 1'b0, 1'b1);
    check("single_data", int'(data), 'h1C);
    pop_n(1);
    check("single_drained", int'(ready), 0);

    // Ordering and overflow.
    do_reset();
    for (int i = 1; i <= 9; i++) send_frame(frame_of(8'(i)), 11, 1'b0, 1'b0);
    check("ovf_flag", int'(overflow), 1);
    for (int i = 1; i <= 8; i++) begin
      check("ovf_order", int'(data), i);
      pop_n(1);
    end
    check("ovf_9_absent", int'(ready), 0);

    // Parity error then a good frame.
    do_reset();
    send_frame(frame_of(8'h5A) ^ 11'h200, 11, 1'b0, 1'b0);
    check("par_err", int'(frame_err), 1);
    check("par_not_ready", int'(ready), 0);
    send_frame(frame_of(8'h5A), 11, 1'b0, 1'b0);
    check("par_good_data", int'(data), 'h5A);

    // Timeout on a partial frame.
    do_reset();
    send_frame(frame_of(8'hF0), 5, 1'b0, 1'b0);
    repeat (1200) @(negedge clk);
    send_frame(frame_of(8'hF0), 11, 1'b0, 1'b0);
    check("tmo_data", int'(data), 'hF0);
    check("tmo_no_err", int'(frame_err), 0);

    // Push and pop together into a full FIFO.
    do_reset();
    for (int i = 0; i < 8; i++) send_frame(frame_of(8'(8'hA0 + i)), 11, 1'b0, 1'b0);
    send_frame(frame_of(8'hB8), 11, 1'b1, 1'b0);
    check("sim_no_ovf", int'(overflow), 0);
    check("sim_head", int'(data), 'hA1);
    pop_n(7);
    check("sim_tail", int'(data), 'hB8);
    pop_n(1);
    check("sim_occupancy_8", int'(ready), 0);

    // Reset mid-frame.
    do_reset();
    send_frame(frame_of(8'h33), 5, 1'b0, 1'b0);
    do_reset();
    send_frame(frame_of(8'h44), 11, 1'b0, 1'b0);
    check("rstmid_data", int'(data), 'h44);
    pop_n(1);
    check("rstmid_only_one", int'(ready), 0);

    // Random traffic: good frames, corrupted frames, pops of varying length.
    do_reset();
    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 9);
      b = 8'($urandom_range(0, 255));
      if (r < 6) begin
        send_frame(frame_of(b), 11, ($urandom_range(0, 3) == 0), 1'b0);
      end else if (r < 7) begin
        f   = frame_of(b);
        sel = $urandom_range(0, 3);
        case (sel)
          0:       f[0]  = ~f[0];
          1:       f[9]  = ~f[9];
          2:       f[10] = ~f[10];
          default: f[$urandom_range(1, 8)] = ~f[$urandom_range(1, 8)];
        endcase
        send_frame(f, 11, 1'b0, 1'b0);
      end else begin
        pop_n($urandom_range(1, 3));
      end
    end
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
